// File: rtl/nne_pool_pkg.sv
// Shared definitions for the pooling stage: data width, row-phase state type
// and the sign-magnitude maximum used by every comparator in the datapath.
package nne_pool_pkg;

    localparam int DATA_W = 32;

    // Row phase: even rows fill the line buffer, odd rows drain it into outputs.
    typedef enum logic [0:0] {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_e;

    // Maximum of two IEEE-754 singles under a sign-magnitude total order.
    // NaN patterns are not special-cased; they compare as plain bit patterns.
    // Ties (including +0 against -0) resolve to the first operand so that the
    // nesting order of comparators decides which bit pattern survives.
    function automatic logic [DATA_W-1:0] fmax(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        if ((a[DATA_W-2:0] == 31'd0) && (b[DATA_W-2:0] == 31'd0)) begin
            // Both are zeros of either sign: equal in value.
            r = a;
        end else if (a[DATA_W-1] != b[DATA_W-1]) begin
            // Differing signs: the non-negative operand wins.
            r = a[DATA_W-1] ? b : a;
        end else if (a[DATA_W-1] == 1'b0) begin
            // Both positive: larger magnitude wins.
            r = (b[DATA_W-2:0] > a[DATA_W-2:0]) ? b : a;
        end else begin
            // Both negative: smaller magnitude wins.
            r = (b[DATA_W-2:0] < a[DATA_W-2:0]) ? b : a;
        end
        return r;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Simple dual-port row buffer holding one horizontal pair-maximum per
// output column. Storage is intentionally not reset: every entry is written
// during an even row before the following odd row reads it.
module pool_line_buffer
    import nne_pool_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; the value holds until the next read is issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= {DATA_W{1'b0}};
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max pooling on a raster-ordered valid-only pixel
// stream. Even rows reduce horizontal pairs into the line buffer; odd rows
// reduce their own pairs and combine them with the buffered value to emit
// one pooled pixel per window.
module maxpool_2x2_stream
    import nne_pool_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              frame_done
);

    localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    // Position counters and row phase.
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    row_state_e        r_state;
    logic [DATA_W-1:0] r_pair;

    // Output registers.
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;
    logic              r_frame_done;

    // Decoded control and datapath nets.
    logic              w_col_last;
    logic              w_row_last;
    logic              w_second_px;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_out_en;
    logic [AW-1:0]     w_addr;
    logic [RW-1:0]     w_row_nxt;
    row_state_e        w_state_nxt;
    logic [DATA_W-1:0] w_pair_max;
    logic [DATA_W-1:0] w_buf_rd;
    logic [DATA_W-1:0] w_win_max;

    assign w_col_last  = (r_col == CW'(IMG_W - 1));
    assign w_row_last  = (r_row == RW'(IMG_H - 1));
    // Column LSB is the pair phase: 0 = first pixel of a pair, 1 = second.
    assign w_second_px = r_col[0];
    assign w_addr      = AW'(r_col >> 1);

    // Line-buffer writes happen only on even rows and reads only on odd rows,
    // so the two ports are never active in the same cycle.
    assign w_wr_en  = valid_in && (r_state == ROW_EVEN) && w_second_px;
    assign w_rd_en  = valid_in && (r_state == ROW_ODD)  && !w_second_px;
    assign w_out_en = valid_in && (r_state == ROW_ODD)  && w_second_px;

    // Comparator order matters for signed-zero ties: the current row's pair
    // is the left operand at every level.
    assign w_pair_max = fmax(r_pair, data_in);
    assign w_win_max  = fmax(w_pair_max, w_buf_rd);

    // Next row index and row phase taken at the end of each row.
    always_comb begin
        w_row_nxt   = w_row_last ? {RW{1'b0}} : (r_row + RW'(1));
        w_state_nxt = ROW_EVEN;
        case (r_state)
            ROW_EVEN: w_state_nxt = ROW_ODD;
            ROW_ODD:  w_state_nxt = ROW_EVEN;
            default:  w_state_nxt = ROW_EVEN;
        endcase
    end

    // Column/row counters and row-phase FSM, advanced only by valid pixels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col   <= {CW{1'b0}};
            r_row   <= {RW{1'b0}};
            r_state <= ROW_EVEN;
        end else if (valid_in) begin
            if (w_col_last) begin
                r_col   <= {CW{1'b0}};
                r_row   <= w_row_nxt;
                r_state <= w_state_nxt;
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Capture the first pixel of each horizontal pair; holds across gaps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pair <= {DATA_W{1'b0}};
        end else if (valid_in && !w_second_px) begin
            r_pair <= data_in;
        end
    end

    // Output registers: pulse valid/frame_done, hold data between results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_out   <= {DATA_W{1'b0}};
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= w_out_en;
            r_frame_done <= w_out_en && w_row_last && w_col_last;
            if (w_out_en) begin
                r_data_out <= w_win_max;
            end
        end
    end

    pool_line_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_addr),
        .i_wr_data (w_pair_max),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_addr),
        .o_rd_data (w_buf_rd)
    );

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign frame_done = r_frame_done;

endmodule

// File: doc/maxpool_2x2_stream.md
# maxpool_2x2_stream

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the ReLU core in the convolution datapath. It consumes the ReLU output stream, one IEEE-754 single-precision pixel per valid cycle in raster order, and emits one pooled pixel per 2×2 window. It has no back-pressure, matching the ReLU core's valid-only interface. One row of partial maxima is buffered internally.

## Interface
- IMG_W, 28: input feature-map width in pixels; even, ≥ 2.
- IMG_H, 28: input feature-map height in rows; even, ≥ 2.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- data_in  in  32  IEEE-754 single-precision pixel.
- valid_in  in  1  data_in is valid this cycle; any gap pattern is allowed.
- data_out  out  32  pooled pixel.
- valid_out  out  1  one-cycle pulse per pooled pixel.
- frame_done  out  1  one-cycle pulse, coincident with the last pooled pixel of a frame.

## Operation
- Counters:
  - col: 0..IMG_W-1.
  - row: 0..IMG_H-1.
  - Both advance only on valid_in. col wraps to 0 and row increments; row wraps to 0 after IMG_H-1, so frames run back-to-back with no idle cycles required.
- Row FSM, 2 states:
  - ROW_EVEN: entered on reset and whenever row is even.
  - ROW_ODD: entered whenever row is odd.
  - Transitions occur on the valid_in that completes col = IMG_W-1.
- Pair phase is col[0]. On col[0] = 0, data_in is latched into pair_reg.
- ROW_EVEN, col[0] = 1:
  - Compute m = fmax(pair_reg, data_in).
  - Write m to line buffer address col>>1.
  - No output.
- ROW_ODD, col[0] = 0:
  - Latch data_in into pair_reg.
  - Issue a line-buffer read at address col>>1. Read data is registered and is held until the next read.
- ROW_ODD, col[0] = 1:
  - Compute data_out = fmax(fmax(pair_reg, data_in), buf_rd).
  - Assert valid_out.
  - Assert frame_done as well if row = IMG_H-1 and col = IMG_W-1.
- fmax(a, b) uses a sign-magnitude total order:
  - Differing signs: the positive operand wins.
  - Both positive: the larger [30:0] wins.
  - Both negative: the smaller [30:0] wins.
  - Equal values, including +0 vs −0: return a.
  - NaN is not detected and is treated as ordinary bit patterns.
- Output count per frame: (IMG_W/2)·(IMG_H/2).
- Reset values:
  - data_out = 0, valid_out = 0, frame_done = 0.
  - col = 0, row = 0, state = ROW_EVEN, pair_reg = 0.
  - Line buffer contents are not reset. Every entry is written in ROW_EVEN before it is read in ROW_ODD.
- Reset mid-frame: the partial frame is discarded and no output is produced for it. The first valid_in after rst deasserts is pixel (0,0).

## Timing
- Latency: valid_out rises on the clock edge after the valid_in carrying pixel (odd row, odd col).
- data_out holds its last value while valid_out = 0.
- Back-to-back valid_in at full rate is supported. Minimum output spacing is 2 cycles; valid_out never rises on two consecutive cycles.
- Line-buffer read/write conflicts:
  - A read in ROW_ODD at address k always follows the write of address k from the preceding even row, so no same-address collision occurs within a frame.
  - A write and a read never occur in the same cycle.
- A gap in valid_in between the two pixels of a pair is allowed: pair_reg and the registered read data hold until the second pixel arrives.
- rst low overrides valid_in in the same cycle.

## Structure
- Package nne_pool_pkg contains:
  - DATA_W = 32.
  - The fmax function.
  - The row-state enum {ROW_EVEN, ROW_ODD}.
- Sub-module pool_line_buffer:
  - Simple dual-port, (IMG_W/2) × DATA_W.
  - One synchronous write port and one synchronous read port, registered output.
  - No reset on the storage array.
- Top level contains: counters, FSM, pair_reg, the two fmax comparators, and the output registers.

## Test plan
- IMG_W = 4, IMG_H = 4; pixels 1.0..16.0 in raster order, continuous valid_in -> outputs 6.0, 8.0, 14.0, 16.0. frame_done pulses with 16.0. Each valid_out comes 1 cycle after pixels 6, 8, 14, 16.
- Same frame with valid_in toggling 1/0 every cycle -> identical outputs and values. Each valid_out comes 1 cycle after the qualifying pixel.
- Window {0x3F800000, 0x00000000, 0x80000000, 0x40000000} (1.0, +0, −0, 2.0) -> 0x40000000. Window {+0, −0, +0, −0} -> 0x00000000.
- Two frames back-to-back with no idle cycles -> 8 outputs and 2 frame_done pulses; the second frame's values are not contaminated by the first.
- Assert rst low after pixel 10 of frame 1, then send a full new frame -> no output from frame 1. The new frame's 4 outputs are correct and all outputs read 0 during reset.
- Odd-row pixel pattern 100.0 at (1,0) and all other pixels 0 -> first output 100.0, remaining outputs 0.
